instr_encoder: RTL and testbench

Inverse of the datapath's instruction decode stage. Accepts decoded instruction fields (opcode class, register indices, funct3/funct7, sign-magnitude immediate) over a valid/ready handshake and packs them into a 32-bit RV32I word. Each word is written to instruction memory at an auto-incrementing word address. Used by the test/program loader to build programs for the multi-cycle datapath from the same field representation the decoder produces.

---
 rtl/instr_encoder.sv | 170 +++++++++++++++++
 tb/tb_instr_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs decoded RV32I instruction fields back into 32-bit words and writes them
// to instruction memory at an auto-incrementing, word-aligned byte address.
module instr_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        instr_type,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [11:0]       immediate,
    input  logic              negative,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] count,
    output logic              error
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned IMM_W  = 13;

    localparam logic [2:0] T_LOAD  = 3'b000;
    localparam logic [2:0] T_ARITH = 3'b001;
    localparam logic [2:0] T_STORE = 3'b010;
    localparam logic [2:0] T_REG   = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b110;

    localparam logic [ADDR_W-1:0] BASE_ALIGNED = ADDR_W'(BASE_ADDR) & ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]  itype;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] mag;
        logic        neg;
    } bundle_t;

    state_t             state_q, state_d;
    bundle_t            bundle_q, bundle_d;
    logic [ADDR_W-1:0]  addr_d, count_d;
    logic [WORD_W-1:0]  wdata_d;
    logic               error_d, in_ready_d, mem_we_d;

    logic [IMM_W-1:0]   imm;
    logic [6:0]         opcode;
    logic [WORD_W-1:0]  word;
    logic               legal;

    // Encode the latched bundle and decide whether it can be written.
    always_comb begin
        opcode = 7'b0000000;
        word   = '0;
        legal  = 1'b0;
        imm    = bundle_q.neg ? (IMM_W'(0) - {1'b0, bundle_q.mag}) : {1'b0, bundle_q.mag};
        case (bundle_q.itype)
            T_LOAD, T_ARITH: begin
                opcode = (bundle_q.itype == T_LOAD) ? 7'b0000011 : 7'b0010011;
                legal  = bundle_q.neg ? (bundle_q.mag <= 12'd2048) : (bundle_q.mag <= 12'd2047);
                word   = {imm[11:0], bundle_q.rs1, bundle_q.funct3, bundle_q.rd, opcode};
            end
            T_STORE: begin
                opcode = 7'b0100011;
                legal  = bundle_q.neg ? (bundle_q.mag <= 12'd2048) : (bundle_q.mag <= 12'd2047);
                word   = {imm[11:5], bundle_q.rs2, bundle_q.rs1, bundle_q.funct3, imm[4:0], opcode};
            end
            T_REG: begin
                opcode = 7'b0110011;
                legal  = 1'b1;
                word   = {bundle_q.funct7, bundle_q.rs2, bundle_q.rs1, bundle_q.funct3,
                          bundle_q.rd, opcode};
            end
            T_BRANCH: begin
                // 12-bit magnitude caps at 4095, so evenness alone bounds it to 4094.
                opcode = 7'b1100011;
                legal  = ~bundle_q.mag[0];
                word   = {imm[12], imm[10:5], bundle_q.rs2, bundle_q.rs1, bundle_q.funct3,
                          imm[4:1], imm[11], opcode};
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        addr_d   = mem_addr;
        count_d  = count;
        error_d  = error;
        wdata_d  = mem_wdata;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = BASE_ALIGNED;
                    count_d = '0;
                    error_d = 1'b0;
                end
                if (in_valid) begin
                    bundle_d = '{itype: instr_type, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3,
                                 funct7: funct7, mag: immediate, neg: negative};
                    state_d  = ENC;
                end
            end
            ENC: begin
                if (legal) begin
                    wdata_d = word;
                    state_d = WR;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WR: begin
                if (mem_ready) begin
                    addr_d  = mem_addr + ADDR_W'(4);
                    count_d = count + ADDR_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d = (state_d == IDLE);
        mem_we_d   = (state_d == WR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bundle_q  <= '0;
            in_ready  <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ALIGNED;
            mem_wdata <= '0;
            count     <= '0;
            error     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bundle_q  <= bundle_d;
            in_ready  <= in_ready_d;
            mem_we    <= mem_we_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            count     <= count_d;
            error     <= error_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance plus a 4-bit one
// sharing the same stimulus to exercise address wrap.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, mem_ready, negative;
    logic [2:0]  instr_type, funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  funct7;
    logic [11:0] immediate;

    logic        in_ready, mem_we, error;
    logic [7:0]  mem_addr, count;
    logic [31:0] mem_wdata;

    logic        in_ready4, mem_we4, error4;
    logic [3:0]  mem_addr4, count4;
    logic [31:0] mem_wdata4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .immediate(immediate), .negative(negative), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .count(count),
        .error(error)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
        .instr_type(instr_type), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .immediate(immediate), .negative(negative), .mem_we(mem_we4),
        .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_ready(mem_ready), .count(count4),
        .error(error4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle in IDLE, then check the ENC cycle.
    task automatic send(input logic [2:0] t, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [11:0] imm, input logic ng, input logic st);
        instr_type = t; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
        immediate = imm; negative = ng; start = st; in_valid = 1'b1;
        chk("idle_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        start    = 1'b0;
        chk("enc_ready", 32'(in_ready), 32'd0);
        chk("enc_we", 32'(mem_we), 32'd0);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] addr,
                                input logic [31:0] word, input logic [31:0] cnt);
        step();
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), addr);
        chk({tag, "_wdata"}, mem_wdata, word);
        chk({tag, "_busy"}, 32'(in_ready), 32'd0);
        step();
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_we_off"}, 32'(mem_we), 32'd0);
        chk({tag, "_count"}, 32'(count), cnt);
        chk({tag, "_next"}, 32'(mem_addr), (addr + 32'd4) & 32'hFF);
    endtask

    task automatic expect_reject(input string tag, input logic [31:0] addr,
                                 input logic [31:0] cnt);
        step();
        chk({tag, "_error"}, 32'(error), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_addr"}, 32'(mem_addr), addr);
        chk({tag, "_count"}, 32'(count), cnt);
    endtask

    initial begin
        logic [31:0] exp_a4 [5];
        exp_a4 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
        instr_type = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0;
        immediate = '0; negative = 1'b0;
        step();
        step();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        step();

        // addi x5,x1,-1
        send(3'b001, 5'd5, 5'd1, 5'd0, 3'b000, 7'd0, 12'd1, 1'b1, 1'b0);
        expect_write("addi", 32'h00, 32'hFFF08293, 32'd1);

        // add x3,x1,x2 with start in the same cycle, then sw x2,8(x1)
        send(3'b011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 12'd0, 1'b0, 1'b1);
        expect_write("add", 32'h00, 32'h002081B3, 32'd1);
        send(3'b010, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'd8, 1'b0, 1'b0);
        expect_write("sw", 32'h04, 32'h0020A423, 32'd2);

        // beq x1,x2,-8 after a restart, then an odd branch offset
        send(3'b110, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 12'd8, 1'b1, 1'b1);
        expect_write("beq", 32'h00, 32'hFE208CE3, 32'd1);
        send(3'b110, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 12'd5, 1'b0, 1'b0);
        expect_reject("sb_odd", 32'h04, 32'd1);

        // Most negative I immediate is legal and lands at the unchanged address
        send(3'b001, 5'd5, 5'd1, 5'd0, 3'b000, 7'd0, 12'd2048, 1'b1, 1'b0);
        expect_write("imm_min", 32'h04, 32'h80008293, 32'd2);
        chk("error_sticky", 32'(error), 32'd1);

        send(3'b001, 5'd5, 5'd1, 5'd0, 3'b000, 7'd0, 12'd2048, 1'b0, 1'b0);
        expect_reject("imm_ovf", 32'h08, 32'd2);
        send(3'b111, 5'd5, 5'd1, 5'd0, 3'b000, 7'd0, 12'd1, 1'b0, 1'b0);
        expect_reject("bad_type", 32'h08, 32'd2);

        // Back-pressure: four cycles of mem_ready=0 with in_valid asserted
        mem_ready = 1'b0;
        send(3'b010, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 12'd8, 1'b0, 1'b0);
        step();
        chk("stall_we0", 32'(mem_we), 32'd1);
        chk("stall_wdata0", mem_wdata, 32'h0020A423);
        instr_type = 3'b001; immediate = 12'd3; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_we", 32'(mem_we), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'h08);
            chk("stall_wdata", mem_wdata, 32'h0020A423);
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        mem_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        chk("stall_done_ready", 32'(in_ready), 32'd1);
        chk("stall_done_count", 32'(count), 32'd3);
        chk("stall_done_addr", 32'(mem_addr), 32'h0C);
        step();
        chk("stall_idle_we", 32'(mem_we), 32'd0);

        // 4-bit address instance: wrap after four words
        start = 1'b1;
        step();
        start = 1'b0;
        chk("w4_start_count", 32'(count4), 32'd0);
        chk("w4_start_addr", 32'(mem_addr4), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send(3'b001, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 12'(i), 1'b0, 1'b0);
            step();
            chk("w4_we", 32'(mem_we4), 32'd1);
            chk("w4_addr", 32'(mem_addr4), exp_a4[i]);
            step();
        end
        chk("w4_count", 32'(count4), 32'd5);
        send(3'b001, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 12'd7, 1'b0, 1'b1);
        step();
        chk("w4_restart_addr", 32'(mem_addr4), 32'd0);
        chk("w4_restart_count0", 32'(count4), 32'd0);
        step();
        chk("w4_restart_count1", 32'(count4), 32'd1);

        // Reset during a stalled write
        mem_ready = 1'b0;
        send(3'b001, 5'd5, 5'd1, 5'd0, 3'b000, 7'd0, 12'd1, 1'b1, 1'b0);
        step();
        chk("rwr_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rwr_we_off", 32'(mem_we), 32'd0);
        chk("rwr_we4_off", 32'(mem_we4), 32'd0);
        chk("rwr_ready", 32'(in_ready), 32'd1);
        chk("rwr_addr", 32'(mem_addr), 32'd0);
        chk("rwr_wdata", mem_wdata, 32'd0);
        chk("rwr_count", 32'(count), 32'd0);
        chk("rwr_error", 32'(error), 32'd0);
        mem_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("rwr_idle_we", 32'(mem_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
